// File: rtl/rv_float_rf_wb_sched.sv
// rtl/rv_float_rf_wb_sched.sv - FP register-file writeback scheduler with issue scoreboard
// Round-robin writeback arbitration into a registered RF write port, plus per-register busy tracking.
module rv_float_rf_wb_sched #(
   parameter int NUM_REGS   = 32,
   parameter int ELEM_WIDTH = 32,
   parameter int NUM_WB     = 2,
   localparam int AW        = $clog2(NUM_REGS)
) (
   input  logic                         clk_i,
   input  logic                         srst_i,
   input  logic                         issue_valid_i,
   input  logic [AW-1:0]                issue_rd_addr_i,
   input  logic                         issue_rd_used_i,
   input  logic [3*AW-1:0]              issue_rs_addr_i,
   input  logic [2:0]                   issue_rs_used_i,
   output logic                         issue_ready_o,
   input  logic [NUM_WB-1:0]            wb_valid_i,
   input  logic [NUM_WB*AW-1:0]         wb_addr_i,
   input  logic [NUM_WB*ELEM_WIDTH-1:0] wb_data_i,
   output logic [NUM_WB-1:0]            wb_ready_o,
   output logic                         rf_wr_en_o,
   output logic [AW-1:0]                rf_wr_addr_o,
   output logic [ELEM_WIDTH-1:0]        rf_wr_data_o,
   output logic [NUM_REGS-1:0]          busy_o,
   output logic                         spurious_o
);

   localparam int PW = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] gnt_idx;
   logic [PW:0]   cand;
   logic          gnt_any;
   logic          hazard;
   logic          issue_fire;

   always_comb begin
      hazard = issue_rd_used_i & busy_o[issue_rd_addr_i];
      for (int i = 0; i < 3; i++) begin
         if (issue_rs_used_i[i] && busy_o[issue_rs_addr_i[i*AW +: AW]]) begin
            hazard = 1'b1;
         end
      end
   end

   assign issue_ready_o = ~srst_i & ~hazard;
   assign issue_fire    = issue_valid_i & issue_ready_o & issue_rd_used_i;

   // Scan requesters starting at the pointer, wrapping modulo NUM_WB; first valid wins.
   always_comb begin
      wb_ready_o = '0;
      gnt_idx    = '0;
      gnt_any    = 1'b0;
      cand       = '0;
      if (!srst_i) begin
         for (int i = 0; i < NUM_WB; i++) begin
            cand = {1'b0, rr_ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(NUM_WB)) begin
               cand = cand - (PW+1)'(NUM_WB);
            end
            if (!gnt_any && wb_valid_i[cand[PW-1:0]]) begin
               gnt_any = 1'b1;
               gnt_idx = cand[PW-1:0];
            end
         end
         if (gnt_any) begin
            wb_ready_o[gnt_idx] = 1'b1;
         end
      end
   end

   assign spurious_o = ~srst_i & rf_wr_en_o & ~busy_o[rf_wr_addr_o];

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         busy_o       <= '0;
         rf_wr_en_o   <= 1'b0;
         rf_wr_addr_o <= '0;
         rf_wr_data_o <= '0;
         rr_ptr       <= '0;
      end else begin
         rf_wr_en_o <= gnt_any;
         if (gnt_any) begin
            rf_wr_addr_o <= wb_addr_i[gnt_idx*AW +: AW];
            rf_wr_data_o <= wb_data_i[gnt_idx*ELEM_WIDTH +: ELEM_WIDTH];
            rr_ptr       <= (gnt_idx == PW'(NUM_WB-1)) ? '0 : gnt_idx + 1'b1;
         end
         // Clear first so a same-register set at this edge takes precedence.
         if (rf_wr_en_o) begin
            busy_o[rf_wr_addr_o] <= 1'b0;
         end
         if (issue_fire) begin
            busy_o[issue_rd_addr_i] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rv_float_rf_wb_sched.sv
// tb/tb_rv_float_rf_wb_sched.sv - self-checking bench for rv_float_rf_wb_sched
// Behavioural scoreboard model checked every cycle, plus directed literal scenarios and random traffic.
module tb_rv_float_rf_wb_sched;

   localparam int NR = 32;
   localparam int EW = 32;
   localparam int NW = 2;
   localparam int AW = 5;

   logic              clk = 1'b0;
   logic              srst_i;
   logic              issue_valid_i;
   logic [AW-1:0]     issue_rd_addr_i;
   logic              issue_rd_used_i;
   logic [3*AW-1:0]   issue_rs_addr_i;
   logic [2:0]        issue_rs_used_i;
   logic              issue_ready_o;
   logic [NW-1:0]     wb_valid_i;
   logic [NW*AW-1:0]  wb_addr_i;
   logic [NW*EW-1:0]  wb_data_i;
   logic [NW-1:0]     wb_ready_o;
   logic              rf_wr_en_o;
   logic [AW-1:0]     rf_wr_addr_o;
   logic [EW-1:0]     rf_wr_data_o;
   logic [NR-1:0]     busy_o;
   logic              spurious_o;

   always #5 clk = ~clk;

   rv_float_rf_wb_sched #(.NUM_REGS(NR), .ELEM_WIDTH(EW), .NUM_WB(NW)) dut (
      .clk_i(clk), .srst_i(srst_i),
      .issue_valid_i(issue_valid_i), .issue_rd_addr_i(issue_rd_addr_i),
      .issue_rd_used_i(issue_rd_used_i), .issue_rs_addr_i(issue_rs_addr_i),
      .issue_rs_used_i(issue_rs_used_i), .issue_ready_o(issue_ready_o),
      .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
      .wb_ready_o(wb_ready_o), .rf_wr_en_o(rf_wr_en_o), .rf_wr_addr_o(rf_wr_addr_o),
      .rf_wr_data_o(rf_wr_data_o), .busy_o(busy_o), .spurious_o(spurious_o)
   );

   bit            m_busy [NR];
   bit            m_en;
   int            m_addr;
   logic [EW-1:0] m_data;
   int            m_ptr;

   bit            req_v [NW];
   logic [AW-1:0] req_a [NW];
   logic [EW-1:0] req_d [NW];

   int            n_chk;
   int            n_pass;
   logic [NW-1:0] act_gnt;
   logic [NW-1:0] last_eg;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic drive_wb();
      for (int j = 0; j < NW; j++) begin
         wb_valid_i[j]          = req_v[j];
         wb_addr_i[j*AW +: AW]  = req_a[j];
         wb_data_i[j*EW +: EW]  = req_d[j];
      end
   endtask

   // Called just after a falling edge with inputs applied; returns after the next falling edge.
   task automatic step();
      bit            haz;
      bit            erdy;
      bit            espur;
      int            k;
      int            c;
      logic [NW-1:0] eg;
      logic [NR-1:0] eb;
      #3;
      haz = issue_rd_used_i && m_busy[issue_rd_addr_i];
      for (int i = 0; i < 3; i++)
         if (issue_rs_used_i[i] && m_busy[issue_rs_addr_i[i*AW +: AW]]) haz = 1'b1;
      erdy = !srst_i && !haz;
      eg = '0;
      k  = -1;
      if (!srst_i) begin
         for (int i = 0; i < NW; i++) begin
            c = (m_ptr + i) % NW;
            if (k < 0 && wb_valid_i[c]) k = c;
         end
      end
      if (k >= 0) eg[k] = 1'b1;
      espur = !srst_i && m_en && !m_busy[m_addr];
      for (int i = 0; i < NR; i++) eb[i] = m_busy[i];
      act_gnt = wb_ready_o;
      last_eg = eg;
      chk("issue_ready", issue_ready_o, erdy);
      chk("wb_ready", wb_ready_o, eg);
      chk("spurious", spurious_o, espur);
      chk("rf_wr_en", rf_wr_en_o, m_en);
      chk("busy", busy_o, eb);
      if (m_en) begin
         chk("rf_wr_addr", rf_wr_addr_o, m_addr);
         chk("rf_wr_data", rf_wr_data_o, m_data);
      end
      @(posedge clk);
      if (srst_i) begin
         for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
         m_en   = 1'b0;
         m_addr = 0;
         m_data = '0;
         m_ptr  = 0;
      end else begin
         if (m_en) m_busy[m_addr] = 1'b0;
         if (issue_valid_i && erdy && issue_rd_used_i) m_busy[issue_rd_addr_i] = 1'b1;
         m_en = (k >= 0);
         if (k >= 0) begin
            m_addr = wb_addr_i[k*AW +: AW];
            m_data = wb_data_i[k*EW +: EW];
            m_ptr  = (k + 1) % NW;
         end
      end
      @(negedge clk);
   endtask

   task automatic set_req(input int j, input bit v, input int a, input logic [EW-1:0] d);
      req_v[j] = v;
      req_a[j] = AW'(a);
      req_d[j] = d;
      drive_wb();
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      m_en = 1'b0; m_addr = 0; m_data = '0; m_ptr = 0;
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
      srst_i = 1'b1;
      issue_valid_i = 1'b0; issue_rd_addr_i = '0; issue_rd_used_i = 1'b0;
      issue_rs_addr_i = '0; issue_rs_used_i = '0;
      for (int j = 0; j < NW; j++) set_req(j, 1'b0, 0, '0);
      @(negedge clk);
      step();
      step();
      srst_i = 1'b0;
      #1;
      chk("rst_busy", busy_o, 0);
      chk("rst_wr_en", rf_wr_en_o, 0);
      chk("rst_wr_addr", rf_wr_addr_o, 0);
      chk("rst_wr_data", rf_wr_data_o, 0);

      // Round-robin with both requesters held valid
      set_req(0, 1'b1, 1, 32'h1111_0000);
      set_req(1, 1'b1, 2, 32'h2222_0000);
      step(); chk("rr_g0", act_gnt, 2'b01);
      step(); chk("rr_g1", act_gnt, 2'b10);
      step(); chk("rr_g2", act_gnt, 2'b01);
      step(); chk("rr_g3", act_gnt, 2'b10);
      set_req(0, 1'b0, 0, '0);
      set_req(1, 1'b0, 0, '0);
      step();

      // Writeback latency to f5
      issue_valid_i = 1'b1; issue_rd_used_i = 1'b1; issue_rd_addr_i = 5;
      step();
      issue_valid_i = 1'b0; issue_rd_used_i = 1'b0;
      #1 chk("lat_busy5_set", busy_o[5], 1);
      set_req(0, 1'b1, 5, 32'h3F80_0000);
      step(); chk("lat_grant", act_gnt, 2'b01);
      set_req(0, 1'b0, 0, '0);
      #1;
      chk("lat_wr_en", rf_wr_en_o, 1);
      chk("lat_wr_addr", rf_wr_addr_o, 5);
      chk("lat_wr_data", rf_wr_data_o, 32'h3F80_0000);
      chk("lat_busy5_hold", busy_o[5], 1);
      step();
      #1 chk("lat_busy5_clr", busy_o[5], 0);

      // RAW stall on f3
      issue_valid_i = 1'b1; issue_rd_used_i = 1'b1; issue_rd_addr_i = 3;
      step();
      issue_rd_used_i = 1'b0;
      issue_rs_addr_i = 15'd3; issue_rs_used_i = 3'b001;
      #1 chk("raw_busy3", busy_o[3], 1);
      chk("raw_stall0", issue_ready_o, 0);
      set_req(0, 1'b1, 3, 32'hCAFE_0003);
      step();
      set_req(0, 1'b0, 0, '0);
      #1 chk("raw_stall_wport", issue_ready_o, 0);
      chk("raw_wport_addr", rf_wr_addr_o, 3);
      step();
      #1 chk("raw_release", issue_ready_o, 1);
      issue_valid_i = 1'b0; issue_rs_used_i = '0;

      // Set f7 while f2 is on the write port
      issue_valid_i = 1'b1; issue_rd_used_i = 1'b1; issue_rd_addr_i = 2;
      step();
      issue_valid_i = 1'b0;
      set_req(0, 1'b1, 2, 32'h0000_0002);
      step();
      set_req(0, 1'b0, 0, '0);
      issue_valid_i = 1'b1; issue_rd_addr_i = 7;
      step();
      issue_valid_i = 1'b0; issue_rd_used_i = 1'b0;
      #1 chk("sim_busy7", busy_o[7], 1);
      chk("sim_busy2", busy_o[2], 0);

      // Spurious write to non-busy f9
      set_req(0, 1'b1, 9, 32'h1234_5678);
      step();
      set_req(0, 1'b0, 0, '0);
      #1 chk("spur_pulse", spurious_o, 1);
      chk("spur_wr_en", rf_wr_en_o, 1);
      chk("spur_wr_addr", rf_wr_addr_o, 9);
      step();
      #1 chk("spur_end", spurious_o, 0);

      // Reset right after an accept
      set_req(0, 1'b1, 4, 32'hDEAD_BEEF);
      step();
      srst_i = 1'b1;
      set_req(0, 1'b1, 6, 32'h0000_0006);
      set_req(1, 1'b1, 8, 32'h0000_0008);
      step();
      srst_i = 1'b0;
      #1 chk("rstmid_wr_en", rf_wr_en_o, 0);
      chk("rstmid_busy", busy_o, 0);
      step(); chk("rstmid_first_gnt", act_gnt, 2'b01);
      set_req(0, 1'b0, 0, '0);
      set_req(1, 1'b0, 0, '0);
      step();

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         issue_valid_i   = 1'($urandom % 2);
         issue_rd_addr_i = AW'($urandom % 8);
         issue_rd_used_i = ($urandom % 4) != 0;
         for (int i = 0; i < 3; i++) issue_rs_addr_i[i*AW +: AW] = AW'($urandom % 8);
         issue_rs_used_i = 3'($urandom % 8);
         srst_i = ($urandom % 150) == 0;
         for (int j = 0; j < NW; j++) begin
            if (!req_v[j] && ($urandom % 3) == 0) begin
               req_v[j] = 1'b1;
               req_a[j] = AW'($urandom % 8);
               req_d[j] = $urandom;
            end
         end
         drive_wb();
         step();
         for (int j = 0; j < NW; j++) if (last_eg[j]) req_v[j] = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
